clk_div_sched: RTL and testbench

Runtime-programmable clock-divider controller. It generates a divided waveform `clk_out` and a period-start strobe `tick` from `clk`. It also sequences start, stop and divisor changes so that no runt or truncated period is ever produced. It sits between register/config logic and the fixed-ratio divider users, replacing per-ratio divider instances with one configurable, glitch-free source.

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/clk_div_core.sv | 63 ++++++
 rtl/clk_div_sched.sv | 104 ++++++++++
 tb/tb_clk_div_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the runtime-programmable clock divider.
//   state_t : controller state (stopped, running, draining the last period)
//   MIN_DIV : smallest legal divisor
//   hi_of() : number of high cycles in a period of length n
package clk_div_pkg;

  typedef enum logic [1:0] {
    StStop,
    StRun,
    StDrain
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  // Odd divisors spend the extra cycle in the high phase.
  function automatic int unsigned hi_of(input int unsigned n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Counter and waveform generator for the clock divider.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   run       : counting is active in the next cycle
//   load      : replace the active divisor with div on this edge
//   div       : divisor to load
//   boundary  : current cycle is the last of a period (cnt == N-1 while active)
//   clk_out   : registered divided waveform
//   tick      : registered one-cycle strobe on the first cycle of each period
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             boundary,
  output logic             clk_out,
  output logic             tick
);

  logic             active_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] hi_d;
  logic             clk_out_d, tick_d;

  assign boundary = active_q && (cnt_q == div_q - DIV_W'(1));

  // Outputs are computed from next-cycle count and divisor so they can be registered.
  always_comb begin
    div_d = load ? div : div_q;
    hi_d  = DIV_W'(hi_of(32'(div_d)));
    cnt_d = '0;
    // Leaving STOP or crossing a boundary both start a fresh period at 0.
    if (run && active_q && !boundary) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    clk_out_d = run && (cnt_d < hi_d);
    tick_d    = run && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      div_q    <= DIV_W'(DEFAULT_DIV);
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      active_q <= run;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      clk_out  <= clk_out_d;
      tick     <= tick_d;
    end
  end

endmodule

// File: rtl/clk_div_sched.sv
// Runtime-programmable clock-divider controller. Sequences start, stop and divisor
// changes so that every output period is complete (only reset may truncate one).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : run request (level)
//   cfg_valid  : new divisor offered;  cfg_div : offered divisor
//   cfg_ready  : a divisor can be accepted (no divisor pending)
//   cfg_err    : one-cycle pulse after an illegal divisor (< 2) was offered
//   clk_out    : divided waveform;  tick : first cycle of each period
//   busy       : controller is not stopped
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             pend_v_q, pend_v_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             cfg_err_d;
  logic             busy_q;
  logic             boundary;
  logic             load;
  logic             xfer;
  logic             legal;

  assign xfer  = cfg_valid && !pend_v_q;
  assign legal = (cfg_div >= DIV_W'(MIN_DIV));
  // A divisor accepted during a boundary cycle is not yet pending, so it waits a period.
  assign load  = pend_v_q && ((state_q == StStop) || boundary);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStop:  state_d = en ? StRun : StStop;
      // At a boundary a dropped request stops cleanly; mid-period it drains instead.
      StRun,
      StDrain: begin
        if (en)            state_d = StRun;
        else if (boundary) state_d = StStop;
        else               state_d = StDrain;
      end
      default: state_d = StStop;
    endcase
  end

  always_comb begin
    pend_v_d   = pend_v_q;
    div_pend_d = div_pend_q;
    if (load) begin
      pend_v_d = 1'b0;
    end else if (xfer && legal) begin
      pend_v_d   = 1'b1;
      div_pend_d = cfg_div;
    end
    cfg_err_d = xfer && !legal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StStop;
      pend_v_q   <= 1'b0;
      div_pend_q <= '0;
      cfg_err    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_v_q   <= pend_v_d;
      div_pend_q <= div_pend_d;
      cfg_err    <= cfg_err_d;
      busy_q     <= (state_d != StStop);
    end
  end

  assign cfg_ready = !pend_v_q;
  assign busy      = busy_q;

  clk_div_core #(
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .run     (state_d != StStop),
    .load    (load),
    .div     (div_pend_q),
    .boundary(boundary),
    .clk_out (clk_out),
    .tick    (tick)
  );

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: a cycle model pushes expected output
// vectors to a scoreboard when stimulus is driven; they are popped and compared
// after each clock edge. Directed waveform patterns are checked as constants.
module tb_clk_div_sched;

  localparam int unsigned DIV_W       = 8;
  localparam int unsigned DEFAULT_DIV = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready, cfg_err, clk_out, tick, busy;

  clk_div_sched #(
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Vector layout: {busy, cfg_ready, cfg_err, tick, clk_out}
  typedef struct {
    string      tag;
    logic [4:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [31:0] h_clk, h_tick, h_rdy, h_err, h_busy;

  // Reference model: 0 = stop, 1 = run, 2 = drain
  int m_st, m_cnt, m_n, m_pend;
  bit m_pv;

  task automatic m_reset();
    m_st = 0; m_cnt = 0; m_n = DEFAULT_DIV; m_pend = 0; m_pv = 1'b0;
  endtask

  task automatic m_step(input bit e, input bit v, input int d, input string tag);
    bit   bnd, xf, lg, ld;
    int   nst, ncnt;
    exp_t x;
    bnd = (m_st != 0) && (m_cnt == m_n - 1);
    xf  = v && !m_pv;
    lg  = (d >= 2);
    ld  = m_pv && (m_st == 0 || bnd);
    if (e)             nst = 1;
    else if (m_st == 0) nst = 0;
    else if (bnd)      nst = 0;
    else               nst = 2;
    if (ld) m_n = m_pend;
    ncnt = (nst == 0 || m_st == 0 || bnd) ? 0 : m_cnt + 1;
    if (ld) m_pv = 1'b0;
    else if (xf && lg) begin
      m_pv   = 1'b1;
      m_pend = d;
    end
    m_st  = nst;
    m_cnt = ncnt;
    x.tag = tag;
    x.val = {nst != 0, !m_pv, xf && !lg, nst != 0 && ncnt == 0,
             nst != 0 && ncnt < (m_n - m_n / 2)};
    sb.push_back(x);
  endtask

  task automatic step(input bit e, input bit v, input int d);
    exp_t       x;
    logic [4:0] obs;
    en        = e;
    cfg_valid = v;
    cfg_div   = DIV_W'(d);
    m_step(e, v, d, $sformatf("cyc%0d", cyc));
    @(posedge clk);
    #1;
    cyc++;
    obs = {busy, cfg_ready, cfg_err, tick, clk_out};
    h_clk  = {h_clk[30:0], clk_out};
    h_tick = {h_tick[30:0], tick};
    h_rdy  = {h_rdy[30:0], cfg_ready};
    h_err  = {h_err[30:0], cfg_err};
    h_busy = {h_busy[30:0], busy};
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_underflow: got empty queue, required one entry");
    end else begin
      x = sb.pop_front();
      checks++;
      assert (obs === x.val) else begin
        errors++;
        $error("FAIL %s {busy,rdy,err,tick,clk}: got %b required %b", x.tag, obs, x.val);
      end
    end
  endtask

  task automatic check_bits(input string tag, input logic [31:0] hist, input int n,
                            input logic [31:0] exp);
    logic [31:0] got;
    got = hist & 32'((64'd1 << n) - 1);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b required %b (last %0d cycles)", tag, got, exp, n);
    end
  endtask

  task automatic check_now(input string tag);
    logic [4:0] obs;
    obs = {busy, cfg_ready, cfg_err, tick, clk_out};
    checks++;
    assert (obs === 5'b01000) else begin
      errors++;
      $error("FAIL %s {busy,rdy,err,tick,clk}: got %b required 01000", tag, obs);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    h_clk = '0; h_tick = '0; h_rdy = '0; h_err = '0; h_busy = '0;
    m_reset();
    #3;
    check_now("reset_values");
    @(negedge clk);
    rst = 1'b0;

    // Default divisor 6
    for (int i = 0; i < 12; i++) step(1, 0, 0);
    check_bits("n6_clk", h_clk, 12, 32'b111000111000);
    check_bits("n6_tick", h_tick, 12, 32'b100000100000);
    step(0, 0, 0);
    check_bits("stop_after_boundary", h_busy, 1, 32'b0);

    // Divisor 5 written in STOP
    step(0, 1, 5);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    check_bits("n5_clk", h_clk, 11, 32'b01110011100);
    check_bits("n5_ready", h_rdy, 11, 32'b01111111111);
    step(0, 0, 0);

    // Back to 6, then change to 3 at cnt = 2 while running
    step(0, 1, 6);
    step(0, 0, 0);
    for (int i = 0; i < 15; i++) step(1, (i == 3), 3);
    check_bits("n6_to_3_clk", h_clk, 15, 32'b111000110110110);
    check_bits("n6_to_3_ready", h_rdy, 15, 32'b111000111111111);

    // Illegal divisors 1 and 0
    step(1, 1, 1);
    step(1, 0, 0);
    step(1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    check_bits("illegal_err", h_err, 6, 32'b101000);
    check_bits("illegal_clk", h_clk, 6, 32'b110110);

    // Divisor 6 accepted in a boundary cycle applies one period later
    step(1, 1, 6);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    check_bits("late_apply_clk", h_clk, 9, 32'b110111000);

    // Drop en at cnt = 1: period completes, then stop
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    check_bits("drain_clk", h_clk, 8, 32'b11100000);
    check_bits("drain_busy", h_busy, 8, 32'b11111100);

    // Re-enable at cnt = 4 during drain: no gap
    for (int i = 0; i < 12; i++) step((i < 2) || (i > 4), 0, 0);
    check_bits("reenable_clk", h_clk, 12, 32'b111000111000);
    check_bits("reenable_busy", h_busy, 12, 32'hfff);

    // Re-enable in the boundary cycle of a drain
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check_bits("bnd_reenable_clk", h_clk, 8, 32'b11100011);
    check_bits("bnd_reenable_tick", h_tick, 8, 32'b10000010);

    // Asynchronous reset at cnt = 1 with a divisor pending
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    step(1, 1, 4);
    check_bits("pending_ready_low", h_rdy, 1, 32'b0);
    #2;
    rst = 1'b1;
    #1;
    check_now("async_reset_values");
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step(1, 0, 0);
    check_bits("post_reset_clk", h_clk, 12, 32'b111000111000);
    step(1, 0, 0);
    step(0, 0, 0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
